// File: rtl/interval_timer_arbiter.sv
// interval_timer_arbiter: one shared up-counter, granted round-robin to NREQ
// requesters. The owner's interval is loaded, qualified ticks are counted, and
// done pulses to the owner at terminal count before the counter is released.
module interval_timer_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16
) (
  input  logic                    CLK,
  input  logic                    CLR,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   len,
  input  logic                    tick,
  output logic [NREQ-1:0]         gnt,
  output logic                    busy,
  output logic [NREQ-1:0]         done,
  output logic [WIDTH-1:0]        Q
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t                     st, st_n;
  logic [IW-1:0]              owner, owner_n, ptr, ptr_n, win, owner_nxt;
  logic                       found;
  logic [WIDTH-1:0]           limit, limit_n, cnt_n, cnt_inc;
  logic [NREQ-1:0]            gnt_n, done_n, win_oh, owner_oh;
  logic [NREQ-1:0][WIDTH-1:0] len_a;
  int                         j;

  assign len_a     = len;
  assign win_oh    = NREQ'(1) << win;
  assign owner_oh  = NREQ'(1) << owner;
  assign owner_nxt = (owner == IW'(NREQ-1)) ? '0 : owner + IW'(1);
  assign cnt_inc   = Q + WIDTH'(1);

  // Round-robin pick: first set request at or above ptr, wrapping around.
  always_comb begin
    win   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req[j]) begin
        found = 1'b1;
        win   = IW'(j);
      end
    end
  end

  // Next-state and next-datapath values; done is a one-cycle pulse by default.
  always_comb begin
    st_n    = st;
    owner_n = owner;
    ptr_n   = ptr;
    limit_n = limit;
    cnt_n   = Q;
    gnt_n   = gnt;
    done_n  = '0;
    case (st)
      IDLE: begin
        if (found) begin
          st_n    = LOAD;
          owner_n = win;
          gnt_n   = win_oh;
        end
      end
      LOAD: begin
        // A dropped request aborts before the interval is even loaded.
        if (!req[owner]) begin
          st_n  = IDLE;
          gnt_n = '0;
          ptr_n = owner_nxt;
        end else begin
          limit_n = len_a[owner];
          cnt_n   = '0;
          if (len_a[owner] == '0) begin
            st_n   = DONE;
            done_n = owner_oh;
          end else begin
            st_n = RUN;
          end
        end
      end
      RUN: begin
        // Abort takes priority over a terminal tick on the same edge.
        if (!req[owner]) begin
          st_n  = IDLE;
          gnt_n = '0;
          ptr_n = owner_nxt;
        end else if (tick) begin
          cnt_n = cnt_inc;
          if (cnt_inc == limit) begin
            st_n   = DONE;
            done_n = owner_oh;
          end
        end
      end
      DONE: begin
        st_n  = IDLE;
        gnt_n = '0;
        ptr_n = owner_nxt;
      end
      default: st_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) st <= IDLE;
    else      st <= st_n;
  end

  // Datapath and registered outputs; Q holds through IDLE, cleared only in LOAD.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      owner <= '0;
      ptr   <= '0;
      limit <= '0;
      Q     <= '0;
      gnt   <= '0;
      done  <= '0;
      busy  <= 1'b0;
    end else begin
      owner <= owner_n;
      ptr   <= ptr_n;
      limit <= limit_n;
      Q     <= cnt_n;
      gnt   <= gnt_n;
      done  <= done_n;
      busy  <= (st_n != IDLE);
    end
  end

endmodule

// File: tb/tb_interval_timer_arbiter.sv
// Directed bench for interval_timer_arbiter: one task per scenario, inputs
// driven 1 time unit after each rising edge, outputs sampled at the same point.
module tb_interval_timer_arbiter;

  logic        CLK = 1'b0;
  logic        CLR = 1'b1;
  logic        tick = 1'b0;
  logic [3:0]  req = '0;
  logic [63:0] len = '0;
  logic [3:0]  gnt, done;
  logic        busy;
  logic [15:0] Q;
  int          checks = 0;
  int          errors = 0;

  interval_timer_arbiter #(.NREQ(4), .WIDTH(16)) dut (
    .CLK(CLK), .CLR(CLR), .req(req), .len(len), .tick(tick),
    .gnt(gnt), .busy(busy), .done(done), .Q(Q)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    #1 CLR = 1'b0;
    #1;
    checks++;
    if (gnt !== 4'b0 || done !== 4'b0 || busy !== 1'b0 || Q !== 16'd0) begin
      errors++;
      $display("FAIL reset_state got gnt=%b done=%b busy=%b Q=%0d exp all zero", gnt, done, busy, Q);
    end
    step();
    step();
    CLR = 1'b1;
  endtask

  task automatic test_fairness();
    logic [3:0] prev, expg;
    int g;
    prev = 4'b0;
    g = 0;
    for (int i = 0; i < 4; i++) len[i*16 +: 16] = 16'd2;
    tick = 1'b1;
    req = 4'b1111;
    for (int c = 0; c < 40 && g < 5; c++) begin
      step();
      if (gnt !== 4'b0 && prev === 4'b0) begin
        expg = 4'b0001 << (g % 4);
        checks++;
        if (gnt !== expg) begin
          errors++;
          $display("FAIL fair_order grant %0d got %b exp %b", g, gnt, expg);
        end
        g++;
      end
      prev = gnt;
    end
    checks++;
    if (g != 5) begin
      errors++;
      $display("FAIL fair_timeout grants seen %0d exp 5", g);
    end
    req = 4'b0;
    step();
    step();
  endtask

  task automatic test_single();
    logic [3:0] expd;
    len[0 +: 16] = 16'd5;
    tick = 1'b1;
    req = 4'b0001;
    step();
    checks++;
    if (gnt !== 4'b0001 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_grant got gnt=%b busy=%b exp 0001/1", gnt, busy);
    end
    step();
    checks++;
    if (Q !== 16'd0) begin
      errors++;
      $display("FAIL single_load got Q=%0d exp 0", Q);
    end
    for (int n = 1; n <= 5; n++) begin
      step();
      expd = (n == 5) ? 4'b0001 : 4'b0000;
      checks++;
      if (Q !== 16'(n) || done !== expd || gnt !== 4'b0001) begin
        errors++;
        $display("FAIL single_count n=%0d got Q=%0d done=%b gnt=%b exp Q=%0d done=%b gnt=0001", n, Q, done, gnt, n, expd);
      end
    end
    req = 4'b0;
    step();
    checks++;
    if (gnt !== 4'b0 || done !== 4'b0 || busy !== 1'b0 || Q !== 16'd5) begin
      errors++;
      $display("FAIL single_release got gnt=%b done=%b busy=%b Q=%0d exp 0/0/0/5", gnt, done, busy, Q);
    end
  endtask

  task automatic test_zero_len();
    len[2*16 +: 16] = 16'd0;
    req = 4'b0100;
    step();
    checks++;
    if (gnt !== 4'b0100 || Q !== 16'd5 || done !== 4'b0) begin
      errors++;
      $display("FAIL zero_grant got gnt=%b Q=%0d done=%b exp 0100/5/0000", gnt, Q, done);
    end
    step();
    checks++;
    if (done !== 4'b0100 || Q !== 16'd0 || gnt !== 4'b0100) begin
      errors++;
      $display("FAIL zero_done got done=%b Q=%0d gnt=%b exp 0100/0/0100", done, Q, gnt);
    end
    req = 4'b0;
    step();
    checks++;
    if (gnt !== 4'b0 || done !== 4'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_release got gnt=%b done=%b busy=%b exp 0/0/0", gnt, done, busy);
    end
  endtask

  task automatic test_tick_gating();
    logic [4:0]  pat;
    logic [15:0] eq [5];
    logic [3:0]  expd;
    pat = 5'b11001;
    eq = '{16'd1, 16'd1, 16'd1, 16'd2, 16'd3};
    len[1*16 +: 16] = 16'd3;
    tick = 1'b1;
    req = 4'b0010;
    step();
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL tick_grant got %b exp 0010", gnt);
    end
    step();
    checks++;
    if (Q !== 16'd0) begin
      errors++;
      $display("FAIL tick_load got Q=%0d exp 0", Q);
    end
    for (int i = 0; i < 5; i++) begin
      tick = pat[i];
      step();
      expd = (i == 4) ? 4'b0010 : 4'b0000;
      checks++;
      if (Q !== eq[i] || done !== expd) begin
        errors++;
        $display("FAIL tick_step i=%0d got Q=%0d done=%b exp Q=%0d done=%b", i, Q, done, eq[i], expd);
      end
    end
    req = 4'b0;
    tick = 1'b1;
    step();
    checks++;
    if (gnt !== 4'b0 || done !== 4'b0 || Q !== 16'd3) begin
      errors++;
      $display("FAIL tick_release got gnt=%b done=%b Q=%0d exp 0/0/3", gnt, done, Q);
    end
  endtask

  task automatic test_abort();
    len[0 +: 16] = 16'd10;
    tick = 1'b1;
    req = 4'b0011;
    step();
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL abort_grant got %b exp 0001", gnt);
    end
    step();
    for (int n = 1; n <= 4; n++) step();
    checks++;
    if (Q !== 16'd4) begin
      errors++;
      $display("FAIL abort_pre got Q=%0d exp 4", Q);
    end
    req = 4'b0010;
    step();
    checks++;
    if (gnt !== 4'b0 || done !== 4'b0 || busy !== 1'b0 || Q !== 16'd4) begin
      errors++;
      $display("FAIL abort_drop got gnt=%b done=%b busy=%b Q=%0d exp 0/0/0/4", gnt, done, busy, Q);
    end
    step();
    checks++;
    if (gnt !== 4'b0010 || Q !== 16'd4 || done !== 4'b0) begin
      errors++;
      $display("FAIL abort_next got gnt=%b Q=%0d done=%b exp 0010/4/0000", gnt, Q, done);
    end
    step();
    checks++;
    if (Q !== 16'd0) begin
      errors++;
      $display("FAIL abort_load got Q=%0d exp 0", Q);
    end
    req = 4'b0;
    step();
    checks++;
    if (gnt !== 4'b0 || done !== 4'b0) begin
      errors++;
      $display("FAIL abort_second got gnt=%b done=%b exp 0/0", gnt, done);
    end
  endtask

  task automatic test_reset_midrun();
    len[0 +: 16] = 16'd10;
    tick = 1'b1;
    req = 4'b0001;
    step();
    step();
    for (int n = 1; n <= 7; n++) step();
    checks++;
    if (Q !== 16'd7 || gnt !== 4'b0001) begin
      errors++;
      $display("FAIL midrun_pre got Q=%0d gnt=%b exp 7/0001", Q, gnt);
    end
    #2 CLR = 1'b0;
    #1;
    checks++;
    if (Q !== 16'd0 || gnt !== 4'b0 || busy !== 1'b0 || done !== 4'b0) begin
      errors++;
      $display("FAIL midrun_reset got Q=%0d gnt=%b busy=%b done=%b exp all zero", Q, gnt, busy, done);
    end
    req = 4'b1111;
    step();
    CLR = 1'b1;
    step();
    checks++;
    if (gnt !== 4'b0001 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midrun_regrant got gnt=%b busy=%b exp 0001/1", gnt, busy);
    end
    req = 4'b0;
    step();
    step();
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_single();
    test_zero_len();
    test_tick_gating();
    test_abort();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
